// File: rtl/data_path_pipe.sv
// Two-stage pipelined CPU datapath: E1 accepts and reads operands, E2 executes and writes back.
// R0 reads as zero; E2 results are forwarded to E1 reads so back-to-back dependent ops never stall.
module data_path_pipe #(
  parameter int N      = 8,
  parameter int R_SIZE = 3,
  parameter int SW_W   = 10
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              issueValid,
  output logic              issueReady,
  input  logic              writeReg,
  input  logic [2:0]        aluFunc,
  input  logic              aluImmediate,
  input  logic              immSwitches,
  input  logic [R_SIZE-1:0] opD,
  input  logic [R_SIZE-1:0] opS,
  input  logic [N-1:0]      opT,
  input  logic [SW_W-1:0]   switchesIn,
  input  logic              switchValid,
  output logic              switchAck,
  output logic [N-1:0]      displayResult,
  output logic [2:0]        flags,
  output logic              resultValid
);

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_PASSB = 3'd5,
    ALU_SHL1  = 3'd6,
    ALU_SHR1  = 3'd7
  } alu_op_t;

  localparam int NREG = 2 ** R_SIZE;

  logic [N-1:0]      rf [NREG];
  logic              started;

  logic              e2_valid;
  logic              e2_wr;
  alu_op_t           e2_func;
  logic [R_SIZE-1:0] e2_dst;
  logic [N-1:0]      e2_a;
  logic [N-1:0]      e2_b;

  logic [N-1:0]      res;
  logic              res_c;
  logic              wb;
  logic              stall;
  logic              fire;
  logic [N-1:0]      rd_a;
  logic [N-1:0]      rd_b;
  logic [N-1:0]      b_op;
  logic              sw_unused;

  // Only the low N switch bits feed the datapath.
  assign sw_unused = ^switchesIn;

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (e2_func)
      ALU_ADD:   {res_c, res} = {1'b0, e2_a} + {1'b0, e2_b};
      ALU_SUB: begin
        res   = e2_a - e2_b;
        res_c = (e2_a < e2_b);
      end
      ALU_AND:   res = e2_a & e2_b;
      ALU_OR:    res = e2_a | e2_b;
      ALU_XOR:   res = e2_a ^ e2_b;
      ALU_PASSB: res = e2_b;
      ALU_SHL1: begin
        res   = {e2_a[N-2:0], 1'b0};
        res_c = e2_a[N-1];
      end
      ALU_SHR1: begin
        res   = {1'b0, e2_a[N-1:1]};
        res_c = e2_a[0];
      end
      default: begin
        res   = '0;
        res_c = 1'b0;
      end
    endcase
  end

  assign wb = e2_valid & e2_wr & (e2_dst != '0);

  // A register being written back this cycle is read from the ALU result, not the file.
  always_comb begin
    rd_a = (opD == '0) ? '0 : rf[opD];
    rd_b = (opS == '0) ? '0 : rf[opS];
    if (wb && (e2_dst == opD)) rd_a = res;
    if (wb && (e2_dst == opS)) rd_b = res;
    b_op = aluImmediate ? (immSwitches ? switchesIn[N-1:0] : opT) : rd_b;
  end

  assign stall      = issueValid & aluImmediate & immSwitches & ~switchValid;
  assign issueReady = nReset & started & ~stall;
  assign fire       = issueValid & issueReady;
  assign switchAck  = fire & aluImmediate & immSwitches;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      started       <= 1'b0;
      e2_valid      <= 1'b0;
      e2_wr         <= 1'b0;
      e2_func       <= ALU_ADD;
      e2_dst        <= '0;
      e2_a          <= '0;
      e2_b          <= '0;
      displayResult <= '0;
      flags         <= '0;
      resultValid   <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      started     <= 1'b1;
      e2_valid    <= fire;
      resultValid <= e2_valid;
      if (fire) begin
        e2_wr   <= writeReg;
        e2_func <= alu_op_t'(aluFunc);
        e2_dst  <= opD;
        e2_a    <= rd_a;
        e2_b    <= b_op;
      end
      if (e2_valid) begin
        displayResult <= res;
        flags         <= {(res == '0), res[N-1], res_c};
      end
      if (wb) rf[e2_dst] <= res;
    end
  end

endmodule

// File: tb/tb_data_path_pipe.sv
// Bench for data_path_pipe: directed vector table, hand-written handshake/reset sequences,
// and random traffic against a sequential-execution reference model.
module tb_data_path_pipe;
  localparam int N      = 8;
  localparam int R_SIZE = 3;
  localparam int SW_W   = 10;

  logic              clk = 1'b0;
  logic              nReset;
  logic              issueValid;
  logic              issueReady;
  logic              writeReg;
  logic [2:0]        aluFunc;
  logic              aluImmediate;
  logic              immSwitches;
  logic [R_SIZE-1:0] opD;
  logic [R_SIZE-1:0] opS;
  logic [N-1:0]      opT;
  logic [SW_W-1:0]   switchesIn;
  logic              switchValid;
  logic              switchAck;
  logic [N-1:0]      displayResult;
  logic [2:0]        flags;
  logic              resultValid;

  always #5 clk = ~clk;

  data_path_pipe #(.N(N), .R_SIZE(R_SIZE), .SW_W(SW_W)) dut (
    .clk(clk), .nReset(nReset), .issueValid(issueValid), .issueReady(issueReady),
    .writeReg(writeReg), .aluFunc(aluFunc), .aluImmediate(aluImmediate),
    .immSwitches(immSwitches), .opD(opD), .opS(opS), .opT(opT),
    .switchesIn(switchesIn), .switchValid(switchValid), .switchAck(switchAck),
    .displayResult(displayResult), .flags(flags), .resultValid(resultValid)
  );

  typedef struct {
    logic       rst_n;
    logic       iv;
    logic       wr;
    logic [2:0] fn;
    logic       imm;
    logic       isw;
    logic [2:0] d;
    logic [2:0] s;
    logic [7:0] t;
    logic [9:0] sw;
    logic       sv;
  } in_t;

  typedef struct {
    in_t        in;
    logic       erdy;
    logic       ev;
    logic [7:0] er;
    logic [2:0] ef;
  } vec_t;

  typedef struct {
    int r;
    int f;
    int due;
  } pend_t;

  int    checks = 0;
  int    errors = 0;
  int    mreg[8];
  pend_t pq[$];
  int    last_r = 0;
  int    last_f = 0;
  bit    blk = 1'b1;
  int    edges = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(bit rst, bit iv, bit wr, int fn, bit imm, bit isw,
                             int d, int s, int t, int sw, bit sv);
    in_t v;
    v.rst_n = rst;  v.iv = iv;  v.wr = wr;  v.fn = 3'(fn);
    v.imm = imm;    v.isw = isw; v.d = 3'(d); v.s = 3'(s);
    v.t = 8'(t);    v.sw = 10'(sw); v.sv = sv;
    return v;
  endfunction

  // Instructions execute in program order; register state is updated at issue.
  task automatic model_exec(input in_t v);
    int a, b, r, c, sum;
    pend_t p;
    a = mreg[v.d];
    b = v.imm ? (v.isw ? int'(v.sw[7:0]) : int'(v.t)) : mreg[v.s];
    c = 0;
    case (v.fn)
      3'd0: begin sum = a + b; r = sum % 256; c = (sum > 255) ? 1 : 0; end
      3'd1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = b;
      3'd6: begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
      default: begin r = a / 2; c = a % 2; end
    endcase
    if (v.wr && v.d != 0) mreg[v.d] = r;
    p.r = r;
    p.f = ((r == 0) ? 4 : 0) + ((r >= 128) ? 2 : 0) + c;
    p.due = edges + 1;
    pq.push_back(p);
  endtask

  task automatic step(input in_t v, output logic o_rdy, output logic o_ack,
                      output logic o_val, output logic [7:0] o_res, output logic [2:0] o_flg);
    bit e_rdy, e_fire, ev;
    pend_t p;
    @(negedge clk);
    nReset = v.rst_n; issueValid = v.iv; writeReg = v.wr; aluFunc = v.fn;
    aluImmediate = v.imm; immSwitches = v.isw; opD = v.d; opS = v.s;
    opT = v.t; switchesIn = v.sw; switchValid = v.sv;
    #1;
    e_rdy  = v.rst_n && !blk && !(v.iv && v.imm && v.isw && !v.sv);
    e_fire = v.iv && e_rdy;
    o_rdy = issueReady;
    o_ack = switchAck;
    chk("issueReady", 16'(issueReady), 16'(e_rdy));
    chk("switchAck", 16'(switchAck), 16'(e_fire && v.imm && v.isw));
    @(posedge clk);
    edges++;
    if (!v.rst_n) begin
      foreach (mreg[i]) mreg[i] = 0;
      pq.delete();
      last_r = 0;
      last_f = 0;
      blk = 1'b1;
    end else begin
      blk = 1'b0;
      if (e_fire) model_exec(v);
    end
    ev = 1'b0;
    if (pq.size() > 0 && pq[0].due == edges) begin
      p = pq.pop_front();
      ev = 1'b1;
      last_r = p.r;
      last_f = p.f;
    end
    #1;
    o_val = resultValid;
    o_res = displayResult;
    o_flg = flags;
    chk("resultValid", 16'(resultValid), 16'(ev));
    chk("displayResult", 16'(displayResult), 16'(last_r));
    chk("flags", 16'(flags), 16'(last_f));
  endtask

  vec_t tbl[14];
  in_t  idle;

  initial begin
    logic       r_rdy, r_ack, r_val;
    logic [7:0] r_res;
    logic [2:0] r_flg;
    in_t        v;

    foreach (mreg[i]) mreg[i] = 0;
    nReset = 1'b0; issueValid = 1'b0; writeReg = 1'b0; aluFunc = '0;
    aluImmediate = 1'b0; immSwitches = 1'b0; opD = '0; opS = '0;
    opT = '0; switchesIn = '0; switchValid = 1'b0;
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            rst iv wr fn imm isw d  s  t     sw sv       rdy v  res    flags
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0), 1'b0, 0, 8'h00, 3'b000};
    tbl[1]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0), 1'b0, 0, 8'h00, 3'b000};
    tbl[2]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0), 1'b0, 0, 8'h00, 3'b000};
    tbl[3]  = '{mk(1, 1, 0, 0, 1, 0, 1, 0, 0,    0, 0), 1'b1, 0, 8'h00, 3'b000};
    tbl[4]  = '{mk(1, 1, 0, 0, 1, 0, 7, 0, 0,    0, 0), 1'b1, 1, 8'h00, 3'b100};
    tbl[5]  = '{mk(1, 1, 1, 0, 1, 0, 1, 0, 5,    0, 0), 1'b1, 1, 8'h00, 3'b100};
    tbl[6]  = '{mk(1, 1, 1, 0, 1, 0, 1, 0, 3,    0, 0), 1'b1, 1, 8'h05, 3'b000};
    tbl[7]  = '{mk(1, 1, 1, 5, 1, 0, 2, 0, 'hFF, 0, 0), 1'b1, 1, 8'h08, 3'b000};
    tbl[8]  = '{mk(1, 1, 1, 0, 1, 0, 2, 0, 1,    0, 0), 1'b1, 1, 8'hFF, 3'b010};
    tbl[9]  = '{mk(1, 1, 1, 1, 1, 0, 2, 0, 1,    0, 0), 1'b1, 1, 8'h00, 3'b101};
    tbl[10] = '{mk(1, 1, 1, 5, 1, 0, 0, 0, 'h33, 0, 0), 1'b1, 1, 8'hFF, 3'b011};
    tbl[11] = '{mk(1, 1, 0, 0, 1, 0, 0, 0, 0,    0, 0), 1'b1, 1, 8'h33, 3'b000};
    tbl[12] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0), 1'b1, 1, 8'h00, 3'b100};
    tbl[13] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0), 1'b1, 0, 8'h00, 3'b100};

    foreach (tbl[i]) begin
      step(tbl[i].in, r_rdy, r_ack, r_val, r_res, r_flg);
      chk($sformatf("tbl%0d_ready", i), 16'(r_rdy), 16'(tbl[i].erdy));
      chk($sformatf("tbl%0d_valid", i), 16'(r_val), 16'(tbl[i].ev));
      chk($sformatf("tbl%0d_result", i), 16'(r_res), 16'(tbl[i].er));
      chk($sformatf("tbl%0d_flags", i), 16'(r_flg), 16'(tbl[i].ef));
    end

    // Switch handshake: three stalled cycles, then the value arrives.
    for (int i = 0; i < 3; i++) begin
      step(mk(1, 1, 1, 5, 1, 1, 4, 0, 0, 'h3FF, 0), r_rdy, r_ack, r_val, r_res, r_flg);
      chk("sw_stall_ready", 16'(r_rdy), 16'd0);
      chk("sw_stall_ack", 16'(r_ack), 16'd0);
      chk("sw_stall_valid", 16'(r_val), 16'd0);
    end
    step(mk(1, 1, 1, 5, 1, 1, 4, 0, 0, 'h12A, 1), r_rdy, r_ack, r_val, r_res, r_flg);
    chk("sw_go_ack", 16'(r_ack), 16'd1);
    chk("sw_go_ready", 16'(r_rdy), 16'd1);
    step(idle, r_rdy, r_ack, r_val, r_res, r_flg);
    chk("sw_ack_once", 16'(r_ack), 16'd0);
    chk("sw_result_valid", 16'(r_val), 16'd1);
    chk("sw_result", 16'(r_res), 16'h2A);

    // Reset while an op is in flight drops its write and its result.
    step(mk(1, 1, 1, 5, 1, 0, 3, 0, 'h10, 0, 0), r_rdy, r_ack, r_val, r_res, r_flg);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r_rdy, r_ack, r_val, r_res, r_flg);
    chk("midrst_valid0", 16'(r_val), 16'd0);
    step(idle, r_rdy, r_ack, r_val, r_res, r_flg);
    chk("midrst_valid1", 16'(r_val), 16'd0);
    chk("midrst_ready", 16'(r_rdy), 16'd0);
    step(mk(1, 1, 0, 0, 1, 0, 3, 0, 0, 0, 0), r_rdy, r_ack, r_val, r_res, r_flg);
    step(idle, r_rdy, r_ack, r_val, r_res, r_flg);
    chk("midrst_r3_valid", 16'(r_val), 16'd1);
    chk("midrst_r3_zero", 16'(r_res), 16'd0);

    for (int i = 0; i < 3000; i++) begin
      v.rst_n = ($urandom_range(0, 99) != 0);
      v.iv    = ($urandom_range(0, 3) != 0);
      v.wr    = ($urandom_range(0, 3) != 0);
      v.fn    = 3'($urandom_range(0, 7));
      v.imm   = 1'($urandom_range(0, 1));
      v.isw   = ($urandom_range(0, 2) == 0);
      v.d     = 3'($urandom_range(0, 7));
      v.s     = 3'($urandom_range(0, 7));
      v.t     = 8'($urandom_range(0, 255));
      v.sw    = 10'($urandom_range(0, 1023));
      v.sv    = 1'($urandom_range(0, 1));
      step(v, r_rdy, r_ack, r_val, r_res, r_flg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
